// File: rtl/acq_sequencer.sv
// acq_sequencer: sync-triggered FIFO write/read sequencer with frame,
// accumulation and save-cycle counters. Optional: ACQ_SEQ_OVERRUN_EN.
module acq_sequencer #(
    parameter int POINTS    = 10,
    parameter int MEASURES  = 100,
    parameter int SAVES     = 10,
    parameter int RD_DELAY  = 3,
    parameter int CHANNELS  = 1,
    parameter int TRIG_EDGE = 0,
    parameter int PW        = 11,
    parameter int MW        = 17,
    parameter int SW        = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sync,
    input  logic [CHANNELS-1:0] ch_mask,
    input  logic                clr,
    output logic [CHANNELS-1:0] wrreq,
    output logic [CHANNELS-1:0] rdreq,
    output logic [PW-1:0]       cnt_point,
    output logic [MW-1:0]       cnt_measure,
    output logic [SW-1:0]       cnt_save,
    output logic                busy,
    output logic                acc_first,
    output logic                acc_last,
    output logic                save_stb,
    output logic                overrun
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_END
    } state_t;

    localparam logic [PW-1:0] P_WR_END = PW'(POINTS);
    localparam logic [PW-1:0] P_RD_BEG = PW'(RD_DELAY);
    localparam logic [PW-1:0] P_RD_END = PW'(POINTS + RD_DELAY);
    localparam logic [PW-1:0] P_LAST   = PW'(POINTS + RD_DELAY - 1);
    localparam logic [MW-1:0] M_LAST   = MW'(MEASURES - 1);
    localparam logic [SW-1:0] S_LAST   = SW'(SAVES - 1);
    localparam logic          SYNC_RST = (TRIG_EDGE != 0);

    if (POINTS < 1 || MEASURES < 1 || SAVES < 1 || RD_DELAY < 1) begin : g_range_chk
        $error("acq_sequencer: POINTS/MEASURES/SAVES/RD_DELAY must be >= 1");
    end
    if (CHANNELS < 1 || CHANNELS > 8) begin : g_ch_chk
        $error("acq_sequencer: CHANNELS must be 1..8");
    end
    if (POINTS + RD_DELAY > (1 << PW) - 1) begin : g_pw_chk
        $error("acq_sequencer: PW too small for POINTS+RD_DELAY");
    end
    if (MEASURES - 1 > (1 << MW) - 1) begin : g_mw_chk
        $error("acq_sequencer: MW too small for MEASURES-1");
    end
    if (SAVES - 1 > (1 << SW) - 1) begin : g_sw_chk
        $error("acq_sequencer: SW too small for SAVES-1");
    end

    state_t                state_q;
    state_t                state_d;
    logic                  sync_q;
    logic                  trig;
    logic                  run_last;
    logic [CHANNELS-1:0]   mask_q;

    assign trig     = SYNC_RST ? (sync & ~sync_q) : (~sync & sync_q);
    assign run_last = (state_q == S_RUN) && (cnt_point == P_LAST);

    // Previous sync level; resets to the post-edge level so a held line never fires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= SYNC_RST;
        end else begin
            sync_q <= sync;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and the request/flag outputs decoded from the current state.
    always_comb begin
        state_d   = state_q;
        wrreq     = '0;
        rdreq     = '0;
        busy      = 1'b0;
        if (clr) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE:  if (trig) state_d = S_RUN;
                S_RUN:   if (run_last) state_d = S_END;
                S_END:   state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
        if (state_q == S_RUN) begin
            busy = 1'b1;
            if (cnt_point < P_WR_END) begin
                wrreq = mask_q;
            end
            if (cnt_point >= P_RD_BEG && cnt_point < P_RD_END) begin
                rdreq = mask_q;
            end
        end
        acc_first = busy && (cnt_measure == '0);
        acc_last  = busy && (cnt_measure == M_LAST);
    end

    // Point, frame and accumulation counters; they settle as END is entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_point   <= '0;
            cnt_measure <= '0;
            cnt_save    <= '0;
            save_stb    <= 1'b0;
            mask_q      <= '0;
        end else if (clr) begin
            cnt_point   <= '0;
            cnt_measure <= '0;
            cnt_save    <= '0;
            save_stb    <= 1'b0;
            mask_q      <= '0;
        end else begin
            save_stb <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (trig) begin
                        mask_q    <= ch_mask;
                        cnt_point <= '0;
                    end
                end
                S_RUN: begin
                    cnt_point <= cnt_point + 1'b1;
                    if (run_last) begin
                        if (cnt_measure == M_LAST) begin
                            cnt_measure <= '0;
                            save_stb    <= 1'b1;
                            cnt_save    <= (cnt_save == S_LAST) ? '0 : cnt_save + 1'b1;
                        end else begin
                            cnt_measure <= cnt_measure + 1'b1;
                        end
                    end
                end
                S_END:   cnt_point <= '0;
                default: cnt_point <= '0;
            endcase
        end
    end

`ifdef ACQ_SEQ_OVERRUN_EN
    logic ovr_q;

    // Sticky flag for a trigger that lands while a frame is still active.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_q <= 1'b0;
        end else if (clr) begin
            ovr_q <= 1'b0;
        end else if (trig && state_q != S_IDLE) begin
            ovr_q <= 1'b1;
        end
    end

    assign overrun = ovr_q;
`else
    assign overrun = 1'b0;
`endif

endmodule

// File: doc/acq_sequencer.md
# acq_sequencer

Parametrised acquisition sequencer for the Raman capture chain. It waits for the external sync edge and then drives write and read requests to the per-channel sample FIFOs for one frame of POINTS samples. It counts frames into accumulations of MEASURES and accumulations into save cycles of SAVES, and flags the first and last frame of each accumulation to the downstream accumulator. It sits between the sync input conditioning and the FIFO/accumulator datapath.

## Interface
- POINTS, 10: samples per frame (≥1)
- MEASURES, 100: frames per accumulation (≥1)
- SAVES, 10: accumulations per save cycle (≥1)
- RD_DELAY, 3: cycles from first wrreq to first rdreq (≥1)
- CHANNELS, 1: number of FIFO channels (1..8)
- TRIG_EDGE, 0: 0 = frame starts on sync falling edge, 1 = rising edge
- PW / MW / SW, 11 / 17 / 4: widths of cnt_point / cnt_measure / cnt_save
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- sync  in  1  external synchronisation, already synchronised to clk
- ch_mask  in  CHANNELS  channel enables, sampled at trigger
- clr  in  1  synchronous clear of counters, overrun, and any frame in progress
- wrreq  out  CHANNELS  FIFO write requests
- rdreq  out  CHANNELS  FIFO read requests
- cnt_point  out  PW  cycle index within current frame
- cnt_measure  out  MW  frame index within accumulation, 0..MEASURES-1
- cnt_save  out  SW  accumulation index, 0..SAVES-1
- busy  out  1  frame in progress
- acc_first / acc_last  out  1  current frame is first / last of accumulation
- save_stb  out  1  one-cycle pulse when an accumulation completes
- overrun  out  1  sticky: trigger arrived while busy

## Operation
- Reset values: all outputs 0, state IDLE. The internal sync_q register resets to TRIG_EDGE, so a sync already at its post-edge level does not fire.
- trig = (TRIG_EDGE ? sync & ~sync_q : ~sync & sync_q); sync_q <= sync every cycle.
- States: IDLE, RUN, END.
- IDLE: on trig, latch ch_mask, set cnt_point to 0, set busy to 1, and go to RUN.
- RUN: cnt_point increments every cycle.
  - wrreq = latched mask while cnt_point < POINTS.
  - rdreq = latched mask while RD_DELAY ≤ cnt_point < POINTS+RD_DELAY.
  - Move to END after the cycle with cnt_point = POINTS+RD_DELAY-1.
- END (one cycle): busy drops, then the state returns to IDLE.
  - If cnt_measure = MEASURES-1: cnt_measure wraps to 0, save_stb pulses, and cnt_save increments mod SAVES.
  - Otherwise cnt_measure increments by 1.
- acc_first = busy & (cnt_measure == 0); acc_last = busy & (cnt_measure == MEASURES-1).
- clr has priority over everything except reset. It zeroes cnt_point, cnt_measure, cnt_save, wrreq, rdreq, busy, and overrun, and forces IDLE. A trig in the same cycle is dropped.
- Counters never exceed their modulus. Widths must hold POINTS+RD_DELAY, MEASURES-1, and SAVES-1; this is checked by elaboration assertion.

## Timing
- Trigger edge visible on sync at cycle T; first wrreq at T+1. Total wrreq high-time is exactly POINTS cycles.
- First rdreq at T+1+RD_DELAY; rdreq is high for POINTS consecutive cycles. The two windows overlap when RD_DELAY < POINTS.
- busy is high from T+1 to T+POINTS+RD_DELAY inclusive. END occupies cycle T+POINTS+RD_DELAY+1, where save_stb pulses and the counters update.
- Minimum trigger spacing is POINTS+RD_DELAY+2 cycles. A trig in END or RUN is not a new frame.
- Reset asserted mid-frame: wrreq and rdreq drop immediately (asynchronous); no partial counter update.

## Configuration
- ACQ_SEQ_OVERRUN_EN defined: a trig while state ≠ IDLE sets overrun. overrun holds until clr or reset, and the trigger is ignored.
- ACQ_SEQ_OVERRUN_EN undefined: overrun is tied 0; early triggers are silently ignored.

## Test plan
All scenarios use POINTS=10, RD_DELAY=3, MEASURES=4, SAVES=3, CHANNELS=2, TRIG_EDGE=0.
- Basic frame: single sync falling edge at T with ch_mask=2'b11 -> wrreq=11 on T+1..T+10, rdreq=11 on T+4..T+13, busy on T+1..T+13, cnt_measure 0→1 at T+14.
- Accumulation wrap: 4 spaced frames -> acc_first only in frame 0, acc_last only in frame 3, save_stb one pulse after frame 3, cnt_measure=0, cnt_save=1. After 12 frames, cnt_save wraps to 0.
- Masking: ch_mask=2'b01 at trigger, changed to 2'b10 mid-frame -> only bit 0 of wrreq/rdreq toggles for the whole frame.
- Overrun (macro on): second falling edge at T+5 -> frame timing unchanged and overrun=1. clr clears it; with the macro off, overrun stays 0.
- Clear and reset mid-frame: clr at T+6 -> all outputs 0 next cycle, state IDLE. rst_n low at T+6 -> wrreq and rdreq 0 without a clock edge. A sync held high through reset release with TRIG_EDGE=1 -> no frame.
